pec_wei_receiver: RTL and testbench

PEC-side receiver at the far end of the weight-distribution handshake (DISWEIPEC_RdyWei / PECDISWEI_GetWei). It accepts one PEC's weight set: a sparsity flag vector followed by packed nonzero bytes. It stores them in a local bank and serves zero-expanded rows, one per kernel position, to the MAC array on request. One bank; the next set is accepted only after the MAC releases the current one.

---
 rtl/pec_wei_receiver_pkg.sv | 35 +++
 rtl/pec_wei_receiver_wei_row_expand.sv | 25 ++
 rtl/pec_wei_receiver.sv | 153 +++++++++++++++
 tb/tb_pec_wei_receiver.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pec_wei_receiver_pkg.sv
// Shared constants, derived widths and FSM encoding for the PEC weight receiver.
package pec_wei_receiver_pkg;

    localparam int KERNEL_SIZE   = 9;
    localparam int CHANNEL_DEPTH = 32;
    localparam int DATA_WIDTH    = 8;
    localparam int BEAT_WEI      = 8;

    // Total weights (and flag bits) in one set.
    localparam int TOTAL_WEI  = KERNEL_SIZE * CHANNEL_DEPTH;
    // Nonzero count / write pointer width: must hold 0..TOTAL_WEI.
    localparam int NUM_W      = $clog2(TOTAL_WEI + 1);
    localparam int POS_W      = $clog2(KERNEL_SIZE);
    // One extra bit so pointer + offset compares never wrap.
    localparam int IDX_W      = NUM_W + 1;
    localparam int MAX_BEATS  = (TOTAL_WEI + BEAT_WEI - 1) / BEAT_WEI;
    localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Number of set bits in one kernel position's flag word.
    function automatic logic [NUM_W-1:0] popcount(input logic [CHANNEL_DEPTH-1:0] v);
        logic [NUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHANNEL_DEPTH; i++) begin
            n = n + NUM_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pec_wei_receiver_wei_row_expand.sv
// Combinational zero-expansion of one kernel row from the packed nonzero store.
module wei_row_expand
    import pec_wei_receiver_pkg::*;
(
    input  logic [CHANNEL_DEPTH-1:0]            rowFlg,
    input  logic [NUM_W-1:0]                    base,
    input  logic [DATA_WIDTH-1:0]               packedMem [TOTAL_WEI],
    output logic [CHANNEL_DEPTH*DATA_WIDTH-1:0] rowWei
);

    // Walk the channels keeping a running prefix popcount; a set flag reads the
    // packed byte at base + (number of set flags below this channel).
    always_comb begin
        logic [IDX_W-1:0] rank;
        rowWei = '0;
        rank   = {1'b0, base};
        for (int c = 0; c < CHANNEL_DEPTH; c++) begin
            if (rowFlg[c] && (rank < IDX_W'(TOTAL_WEI))) begin
                rowWei[c*DATA_WIDTH +: DATA_WIDTH] = packedMem[rank[NUM_W-1:0]];
            end
            rank = rank + IDX_W'(rowFlg[c]);
        end
    end

endmodule

// File: rtl/pec_wei_receiver.sv
// PEC-side weight receiver: accepts one sparse weight set, stores it packed,
// and serves zero-expanded rows to the MAC array until the bank is released.
//
// Handshakes: distributor side, RdyWei (level) is taken only in IDLE and is
// acknowledged by a one-cycle GetWei pulse; each cycle ValWei is high in RECV
// moves one beat. MAC side, Req is honoured only while WEIMAC_Rdy is high and
// answered by a one-cycle WEIMAC_Val pulse one edge later; Done while Rdy is
// high releases the bank and overrides a same-cycle Req.
module pec_wei_receiver
    import pec_wei_receiver_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                DISWEIPEC_RdyWei,
    input  logic [TOTAL_WEI-1:0]                DISWEIPEC_FlgWei,
    output logic                                PECDISWEI_GetWei,
    input  logic                                DISWEIPEC_ValWei,
    input  logic [BEAT_WEI*DATA_WIDTH-1:0]      DISWEIPEC_Wei,
    input  logic                                MACWEI_Req,
    input  logic [POS_W-1:0]                    MACWEI_Pos,
    input  logic                                MACWEI_Done,
    output logic                                WEIMAC_Rdy,
    output logic                                WEIMAC_Val,
    output logic [CHANNEL_DEPTH-1:0]            WEIMAC_Flg,
    output logic [CHANNEL_DEPTH*DATA_WIDTH-1:0] WEIMAC_Wei,
    output state_t                              dbgState
);

    state_t                          state, nextState;
    logic [TOTAL_WEI-1:0]            flagsReg;
    logic [NUM_W-1:0]                numVal, wrPtr;
    logic [NUM_W-1:0]                baseReg [KERNEL_SIZE];
    logic [NUM_W-1:0]                numValIn;
    logic [NUM_W-1:0]                baseIn [KERNEL_SIZE];
    logic [BEAT_CNT_W-1:0]           beatCnt;
    logic [DATA_WIDTH-1:0]           packedMem [TOTAL_WEI];
    logic [IDX_W-1:0]                wrIdx [BEAT_WEI];
    logic [BEAT_WEI-1:0]             wrEn;
    logic                            acceptSet, acceptBeat, bankRdy, respond, posInRange;
    logic                            lastBeat;
    logic [POS_W-1:0]                rowSel;
    logic [CHANNEL_DEPTH-1:0]        rowFlg;
    logic [CHANNEL_DEPTH*DATA_WIDTH-1:0] rowWei;

    assign acceptSet  = (state == ST_IDLE) && DISWEIPEC_RdyWei;
    assign acceptBeat = (state == ST_RECV) && DISWEIPEC_ValWei &&
                        (beatCnt < BEAT_CNT_W'(MAX_BEATS));
    assign lastBeat   = ({1'b0, wrPtr} + IDX_W'(BEAT_WEI)) >= {1'b0, numVal};
    assign respond    = bankRdy && MACWEI_Req && !MACWEI_Done;
    assign posInRange = MACWEI_Pos < POS_W'(KERNEL_SIZE);
    assign rowSel     = posInRange ? MACWEI_Pos : '0;
    assign rowFlg     = flagsReg[32'(rowSel)*CHANNEL_DEPTH +: CHANNEL_DEPTH];

    // Total nonzero count and per-position base offsets of the incoming flags.
    always_comb begin
        numValIn = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            baseIn[k] = numValIn;
            numValIn  = numValIn + popcount(DISWEIPEC_FlgWei[k*CHANNEL_DEPTH +: CHANNEL_DEPTH]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (acceptSet)               nextState = (numValIn == '0) ? ST_FULL : ST_RECV;
            ST_RECV: if (acceptBeat && lastBeat)  nextState = ST_FULL;
            ST_FULL: if (bankRdy && MACWEI_Done)  nextState = ST_IDLE;
            default:                              nextState = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; an empty set lands in FULL together with the
    // GetWei pulse, so Rdy waits until that pulse has passed.
    always_comb begin
        bankRdy    = (state == ST_FULL) && !PECDISWEI_GetWei;
        WEIMAC_Rdy = bankRdy;
        dbgState   = state;
    end

    // Set bookkeeping: flag latch, counts, write pointer, beat counter, GetWei.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PECDISWEI_GetWei <= 1'b0;
            flagsReg         <= '0;
            numVal           <= '0;
            wrPtr            <= '0;
            beatCnt          <= '0;
            for (int k = 0; k < KERNEL_SIZE; k++) baseReg[k] <= '0;
        end else begin
            PECDISWEI_GetWei <= acceptSet;
            if (acceptSet) begin
                flagsReg <= DISWEIPEC_FlgWei;
                numVal   <= numValIn;
                wrPtr    <= '0;
                beatCnt  <= '0;
                for (int k = 0; k < KERNEL_SIZE; k++) baseReg[k] <= baseIn[k];
            end
            if (acceptBeat) begin
                wrPtr   <= wrPtr + NUM_W'(BEAT_WEI);
                beatCnt <= (beatCnt == BEAT_CNT_W'(MAX_BEATS)) ? beatCnt : beatCnt + 1'b1;
            end
            if (bankRdy && MACWEI_Done) wrPtr <= '0;
        end
    end

    // Per-byte write slots of the current beat; bytes past NumVal are dropped.
    always_comb begin
        for (int j = 0; j < BEAT_WEI; j++) begin
            wrIdx[j] = {1'b0, wrPtr} + IDX_W'(j);
            wrEn[j]  = acceptBeat && (wrIdx[j] < {1'b0, numVal});
        end
    end

    // Packed nonzero store; contents are don't-care across reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < BEAT_WEI; j++) begin
            if (wrEn[j]) packedMem[wrIdx[j][NUM_W-1:0]] <= DISWEIPEC_Wei[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    wei_row_expand rowExpand (
        .rowFlg    (rowFlg),
        .base      (baseReg[rowSel]),
        .packedMem (packedMem),
        .rowWei    (rowWei)
    );

    // Registered row response; out-of-range positions answer with zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WEIMAC_Val <= 1'b0;
            WEIMAC_Flg <= '0;
            WEIMAC_Wei <= '0;
        end else begin
            WEIMAC_Val <= respond;
            WEIMAC_Flg <= '0;
            WEIMAC_Wei <= '0;
            if (respond && posInRange) begin
                WEIMAC_Flg <= rowFlg;
                WEIMAC_Wei <= rowWei;
            end
        end
    end

endmodule

// File: tb/tb_pec_wei_receiver.sv
// Self-checking bench for pec_wei_receiver: directed scenarios plus random sets,
// checked each cycle against a set-level reference model.
module tb_pec_wei_receiver;
    import pec_wei_receiver_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           DISWEIPEC_RdyWei;
    logic [287:0]   DISWEIPEC_FlgWei;
    logic           PECDISWEI_GetWei;
    logic           DISWEIPEC_ValWei;
    logic [63:0]    DISWEIPEC_Wei;
    logic           MACWEI_Req;
    logic [3:0]     MACWEI_Pos;
    logic           MACWEI_Done;
    logic           WEIMAC_Rdy;
    logic           WEIMAC_Val;
    logic [31:0]    WEIMAC_Flg;
    logic [255:0]   WEIMAC_Wei;
    state_t         dbgState;

    pec_wei_receiver dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .DISWEIPEC_RdyWei (DISWEIPEC_RdyWei),
        .DISWEIPEC_FlgWei (DISWEIPEC_FlgWei),
        .PECDISWEI_GetWei (PECDISWEI_GetWei),
        .DISWEIPEC_ValWei (DISWEIPEC_ValWei),
        .DISWEIPEC_Wei    (DISWEIPEC_Wei),
        .MACWEI_Req       (MACWEI_Req),
        .MACWEI_Pos       (MACWEI_Pos),
        .MACWEI_Done      (MACWEI_Done),
        .WEIMAC_Rdy       (WEIMAC_Rdy),
        .WEIMAC_Val       (WEIMAC_Val),
        .WEIMAC_Flg       (WEIMAC_Flg),
        .WEIMAC_Wei       (WEIMAC_Wei),
        .dbgState         (dbgState)
    );

    int checks   = 0;
    int failures = 0;
    int getCount = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 waiting for a set, 1 collecting bytes, 2 holding a complete set.
    int           mPhase;
    logic [287:0] mFlags;
    int           mNum;
    int           mRcv;
    logic [7:0]   mBytes[$];
    logic         eGet, eRdy, eVal;
    logic [287:0] exp_q[$];
    logic [287:0] eResp;

    // Row c byte = the rank-th received nonzero byte, where rank counts set
    // flags earlier in (position, channel) order across the whole set.
    function automatic logic [255:0] model_row(input int p);
        logic [255:0] r;
        int rank;
        r = '0;
        for (int c = 0; c < 32; c++) begin
            if (mFlags[p*32+c]) begin
                rank = 0;
                for (int i = 0; i < p*32+c; i++) if (mFlags[i]) rank++;
                if (rank < mBytes.size()) r[c*8 +: 8] = mBytes[rank];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase = 0; mNum = 0; mRcv = 0; mBytes.delete(); exp_q.delete();
            eGet = 1'b0; eRdy = 1'b0; eVal = 1'b0;
        end else begin
            logic takeSet;
            logic holding;
            takeSet = (mPhase == 0) && DISWEIPEC_RdyWei;
            holding = (mPhase == 2) && !eGet;
            eVal = 1'b0;
            if (takeSet) begin
                mFlags = DISWEIPEC_FlgWei;
                mNum   = $countones(DISWEIPEC_FlgWei);
                mRcv   = 0;
                mBytes.delete();
                mPhase = (mNum > 0) ? 1 : 2;
            end else if (mPhase == 1 && DISWEIPEC_ValWei) begin
                for (int j = 0; j < 8; j++)
                    if (mBytes.size() < mNum) mBytes.push_back(DISWEIPEC_Wei[j*8 +: 8]);
                mRcv += 8;
                if (mRcv >= mNum) mPhase = 2;
            end else if (holding) begin
                if (MACWEI_Done) mPhase = 0;
                else if (MACWEI_Req) begin
                    eVal = 1'b1;
                    if (MACWEI_Pos < 9) exp_q.push_back({mFlags[MACWEI_Pos*32 +: 32], model_row(int'(MACWEI_Pos))});
                    else                exp_q.push_back('0);
                end
            end
            eGet = takeSet;
            eRdy = (mPhase == 2) && !eGet;
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("get_wei", PECDISWEI_GetWei, eGet);
            chk("rdy", WEIMAC_Rdy, eRdy);
            chk("val", WEIMAC_Val, eVal);
            if (exp_q.size() > 0) begin
                eResp = exp_q.pop_front();
                if (WEIMAC_Val) begin
                    chk("resp_flg", WEIMAC_Flg, eResp[287:256]);
                    chk("resp_wei", WEIMAC_Wei, eResp[255:0]);
                end
            end else if (WEIMAC_Val) begin
                chk("resp_unexpected", WEIMAC_Val, 1'b0);
            end
        end
        if (PECDISWEI_GetWei) getCount++;
    end

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    logic [7:0] setBytes [288];
    bit         gapsOn = 0;

    task automatic send_set(input logic [287:0] f, input int maxBeats, input bit holdRdy, output int lat);
        int nv, nb, t;
        logic [63:0] beat;
        DISWEIPEC_RdyWei = 1'b1;
        DISWEIPEC_FlgWei = f;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!PECDISWEI_GetWei && t < 8);
        lat = t;
        if (!PECDISWEI_GetWei) chk("getwei_timeout", PECDISWEI_GetWei, 1'b1);
        if (!holdRdy) DISWEIPEC_RdyWei = 1'b0;
        nv = $countones(f);
        nb = (nv + 7) / 8;
        if (nb > maxBeats) nb = maxBeats;
        for (int b = 0; b < nb; b++) begin
            if (gapsOn) begin
                repeat ($urandom_range(0, 2)) begin
                    DISWEIPEC_ValWei = 1'b0;
                    MACWEI_Req  = 1'($urandom_range(0, 1));
                    MACWEI_Done = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            for (int j = 0; j < 8; j++)
                beat[j*8 +: 8] = (b*8+j < nv) ? setBytes[b*8+j] : 8'($urandom_range(0, 255));
            DISWEIPEC_Wei    = beat;
            DISWEIPEC_ValWei = 1'b1;
            @(negedge clk);
            DISWEIPEC_ValWei = 1'b0;
        end
        MACWEI_Req  = 1'b0;
        MACWEI_Done = 1'b0;
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!WEIMAC_Rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!WEIMAC_Rdy) chk("rdy_timeout", WEIMAC_Rdy, 1'b1);
    endtask

    task automatic do_req(input logic [3:0] p);
        MACWEI_Req = 1'b1;
        MACWEI_Pos = p;
        @(negedge clk);
        MACWEI_Req = 1'b0;
    endtask

    task automatic release_bank(input bit withReq);
        MACWEI_Done = 1'b1;
        MACWEI_Req  = withReq;
        @(negedge clk);
        MACWEI_Done = 1'b0;
        MACWEI_Req  = 1'b0;
    endtask

    task automatic random_reqs();
        int n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) begin
            MACWEI_Req       = ($urandom_range(0, 3) != 0);
            MACWEI_Pos       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            DISWEIPEC_ValWei = 1'($urandom_range(0, 1));
            DISWEIPEC_RdyWei = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        MACWEI_Req = 1'b0;
        DISWEIPEC_ValWei = 1'b0;
        DISWEIPEC_RdyWei = 1'b0;
    endtask

    task automatic random_flags(input int pct, output logic [287:0] f);
        for (int i = 0; i < 288; i++) f[i] = ($urandom_range(0, 99) < pct);
        for (int i = 0; i < 288; i++) setBytes[i] = 8'($urandom_range(0, 255));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [287:0] f;
        logic [255:0] expRow;
        int lat, g0;
        int pcts[5] = '{0, 5, 30, 70, 100};

        DISWEIPEC_RdyWei = 0; DISWEIPEC_FlgWei = '0; DISWEIPEC_ValWei = 0; DISWEIPEC_Wei = '0;
        MACWEI_Req = 0; MACWEI_Pos = '0; MACWEI_Done = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_getwei", PECDISWEI_GetWei, 1'b0);
        chk("reset_rdy", WEIMAC_Rdy, 1'b0);
        chk("reset_val", WEIMAC_Val, 1'b0);
        chk("reset_flg", WEIMAC_Flg, 32'h0);
        chk("reset_wei", WEIMAC_Wei, 256'h0);
        chk("reset_state", dbgState, ST_IDLE);
        rst_n = 1;
        @(negedge clk);

        // Dense set: every weight nonzero, bytes 1..288.
        f = '1;
        for (int i = 0; i < 288; i++) setBytes[i] = 8'(i + 1);
        send_set(f, 36, 0, lat);
        chk("dense_getwei_latency", lat, 1);
        chk("dense_rdy_after_beat36", WEIMAC_Rdy, 1'b1);
        do_req(4'd2);
        for (int c = 0; c < 32; c++) expRow[c*8 +: 8] = 8'(65 + c);
        chk("dense_pos2_val", WEIMAC_Val, 1'b1);
        chk("dense_pos2_flg", WEIMAC_Flg, 32'hFFFF_FFFF);
        chk("dense_pos2_wei", WEIMAC_Wei, expRow);
        release_bank(0);

        // Sparse set: position 0 channels 0 and 2 only.
        f = '0; f[0] = 1'b1; f[2] = 1'b1;
        setBytes[0] = 8'hAA; setBytes[1] = 8'hBB;
        send_set(f, 36, 0, lat);
        chk("sparse_full_after_one_beat", WEIMAC_Rdy, 1'b1);
        do_req(4'd0);
        chk("sparse_pos0_flg", WEIMAC_Flg, 32'h0000_0005);
        chk("sparse_pos0_wei", WEIMAC_Wei, 256'h00BB_00AA);
        do_req(4'd5);
        chk("sparse_pos5_val", WEIMAC_Val, 1'b1);
        chk("sparse_pos5_flg", WEIMAC_Flg, 32'h0);
        chk("sparse_pos5_wei", WEIMAC_Wei, 256'h0);

        // Req and Done together: Done wins.
        MACWEI_Req = 1; MACWEI_Pos = 4'd0; MACWEI_Done = 1;
        @(negedge clk);
        MACWEI_Req = 0; MACWEI_Done = 0;
        chk("reqdone_no_val", WEIMAC_Val, 1'b0);
        chk("reqdone_rdy_low", WEIMAC_Rdy, 1'b0);
        chk("reqdone_idle", dbgState, ST_IDLE);

        // Empty set: Rdy one cycle after GetWei, stray beats ignored.
        send_set('0, 36, 0, lat);
        chk("empty_getwei_high", PECDISWEI_GetWei, 1'b1);
        chk("empty_rdy_with_getwei", WEIMAC_Rdy, 1'b0);
        @(negedge clk);
        chk("empty_rdy_next", WEIMAC_Rdy, 1'b1);
        DISWEIPEC_ValWei = 1; DISWEIPEC_Wei = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (2) @(negedge clk);
        DISWEIPEC_ValWei = 0;
        chk("empty_still_full", WEIMAC_Rdy, 1'b1);
        do_req(4'd9);
        chk("pos9_val", WEIMAC_Val, 1'b1);
        chk("pos9_flg", WEIMAC_Flg, 32'h0);
        chk("pos9_wei", WEIMAC_Wei, 256'h0);
        release_bank(0);

        // RdyWei held through RECV: exactly one GetWei.
        random_flags(50, f);
        g0 = getCount;
        send_set(f, 36, 1, lat);
        wait_rdy();
        DISWEIPEC_RdyWei = 0;
        chk("held_rdy_single_getwei", getCount - g0, 1);
        random_reqs();
        release_bank(0);

        // Reset after 3 of 10 beats, then a fresh set.
        f = '0; f[79:0] = '1;
        for (int i = 0; i < 288; i++) setBytes[i] = 8'($urandom_range(0, 255));
        send_set(f, 3, 0, lat);
        rst_n = 0;
        #1;
        chk("rst_recv_state", dbgState, ST_IDLE);
        chk("rst_recv_rdy", WEIMAC_Rdy, 1'b0);
        chk("rst_recv_getwei", PECDISWEI_GetWei, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 288; i++) setBytes[i] = 8'($urandom_range(0, 255));
        send_set(f, 36, 0, lat);
        chk("after_reset_full", WEIMAC_Rdy, 1'b1);
        do_req(4'd0);
        chk("after_reset_pos0_c0", WEIMAC_Wei[7:0], setBytes[0]);
        do_req(4'd2);
        chk("after_reset_pos2_c15", WEIMAC_Wei[127:120], setBytes[79]);
        release_bank(0);

        // Reset while a response is on the outputs.
        f = '0; f[63:32] = '1;
        for (int i = 0; i < 288; i++) setBytes[i] = 8'(i + 8'h40);
        send_set(f, 36, 0, lat);
        do_req(4'd1);
        chk("full_val_before_reset", WEIMAC_Val, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("rst_full_val", WEIMAC_Val, 1'b0);
        chk("rst_full_rdy", WEIMAC_Rdy, 1'b0);
        chk("rst_full_flg", WEIMAC_Flg, 32'h0);
        chk("rst_full_wei", WEIMAC_Wei, 256'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Back-to-back sets: second set taken the cycle after Done.
        random_flags(70, f);
        send_set(f, 36, 0, lat);
        wait_rdy();
        random_reqs();
        release_bank(0);
        f = '1;
        for (int i = 0; i < 288; i++) setBytes[i] = 8'(i) ^ 8'h5A;
        send_set(f, 36, 0, lat);
        chk("b2b_getwei_latency", lat, 1);
        do_req(4'd8);
        for (int c = 0; c < 32; c++) expRow[c*8 +: 8] = 8'(c) ^ 8'h5A;
        chk("b2b_pos8_wei", WEIMAC_Wei, expRow);
        chk("b2b_pos8_flg", WEIMAC_Flg, 32'hFFFF_FFFF);
        release_bank(0);

        // Random sets with stray events.
        for (int n = 0; n < 24; n++) begin
            random_flags(pcts[$urandom_range(0, 4)], f);
            gapsOn = 1'($urandom_range(0, 1));
            send_set(f, 36, 0, lat);
            wait_rdy();
            random_reqs();
            release_bank(1'($urandom_range(0, 1)));
        end
        gapsOn = 0;
        repeat (2) @(negedge clk);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
